system_counter_pio: RTL and testbench

SYSTEM_COUNTER_PIO -- requirements
Module: system_counter_pio

---
 rtl/system_counter_pio_pkg.sv | 14 +
 rtl/system_counter_pio_if.sv | 20 ++
 rtl/system_counter_pio_alu.sv | 30 +++
 rtl/system_counter_pio.sv | 96 +++++++++
 tb/tb_system_counter_pio.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/system_counter_pio_pkg.sv
// Shared register map and CTRL bit positions for the system counter PIO.
package system_counter_pio_pkg;

   localparam logic [1:0] ADDR_DATA   = 2'd0;
   localparam logic [1:0] ADDR_CTRL   = 2'd1;
   localparam logic [1:0] ADDR_STEP   = 2'd2;
   localparam logic [1:0] ADDR_STATUS = 2'd3;

   localparam int CTRL_SAT  = 0;
   localparam int CTRL_DIR  = 1;
   localparam int CTRL_IE   = 2;
   localparam int CTRL_BITS = 3;

endpackage

// File: rtl/system_counter_pio_if.sv
// Avalon-MM slave bus bundle for the system counter PIO.
interface system_counter_pio_if;

   logic [1:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [31:0] writedata;
   logic [31:0] readdata;

   modport master (
      output address, chipselect, write_n, writedata,
      input  readdata
   );

   modport slave (
      input  address, chipselect, write_n, writedata,
      output readdata
   );

endinterface

// File: rtl/system_counter_pio_alu.sv
// Combinational add/subtract with optional saturation; ovf flags carry or borrow out of WIDTH bits.
module system_counter_pio_alu #(
   parameter int WIDTH = 6
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             dir,
   input  logic             sat,
   output logic [WIDTH-1:0] result,
   output logic             ovf
);

   logic [WIDTH:0] sum_ext;
   logic [WIDTH:0] diff_ext;

   always_comb begin
      sum_ext  = {1'b0, a} + {1'b0, b};
      diff_ext = {1'b0, a} - {1'b0, b};
      result   = a;
      ovf      = 1'b0;
      if (dir) begin
         ovf    = diff_ext[WIDTH];
         result = (ovf && sat) ? '0 : diff_ext[WIDTH-1:0];
      end else begin
         ovf    = sum_ext[WIDTH];
         result = (ovf && sat) ? '1 : sum_ext[WIDTH-1:0];
      end
   end

endmodule

// File: rtl/system_counter_pio.sv
// Avalon-MM counter PIO: DATA/CTRL/STEP/STATUS registers driving out_port.
// Optional interrupt output enabled by defining SYSTEM_COUNTER_PIO_IRQ_EN.
module system_counter_pio
   import system_counter_pio_pkg::*;
#(
   parameter int WIDTH       = 6,
   parameter int RESET_VALUE = 0
) (
   input  logic                 clk,
   input  logic                 reset_n,
   system_counter_pio_if.slave  avs,
   output logic [WIDTH-1:0]     out_port
`ifdef SYSTEM_COUNTER_PIO_IRQ_EN
   ,
   output logic                 irq
`endif
);

   localparam logic [WIDTH-1:0] DATA_RST = WIDTH'(RESET_VALUE);
`ifdef SYSTEM_COUNTER_PIO_IRQ_EN
   localparam logic [CTRL_BITS-1:0] CTRL_MASK = 3'b111;
`else
   localparam logic [CTRL_BITS-1:0] CTRL_MASK = 3'b011;
`endif

   logic [WIDTH-1:0]     data_q, data_d;
   logic [CTRL_BITS-1:0] ctrl_q, ctrl_d;
   logic                 ovf_q, ovf_d;
   logic                 wr;
   logic [WIDTH-1:0]     wdata_w;
   logic [WIDTH-1:0]     alu_result;
   logic                 alu_ovf;
   logic                 unused_wdata;

   assign wr           = avs.chipselect & ~avs.write_n;
   assign wdata_w      = avs.writedata[WIDTH-1:0];
   assign unused_wdata = ^avs.writedata;

   system_counter_pio_alu #(.WIDTH(WIDTH)) u_alu (
      .a      (data_q),
      .b      (wdata_w),
      .dir    (ctrl_q[CTRL_DIR]),
      .sat    (ctrl_q[CTRL_SAT]),
      .result (alu_result),
      .ovf    (alu_ovf)
   );

   always_comb begin
      data_d = data_q;
      ctrl_d = ctrl_q;
      ovf_d  = ovf_q;
      if (wr) begin
         case (avs.address)
            ADDR_DATA:   data_d = wdata_w;
            ADDR_CTRL:   ctrl_d = avs.writedata[CTRL_BITS-1:0] & CTRL_MASK;
            ADDR_STEP: begin
               data_d = alu_result;
               if (alu_ovf) ovf_d = 1'b1;
            end
            ADDR_STATUS: if (avs.writedata[0]) ovf_d = 1'b0;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         data_q <= DATA_RST;
         ctrl_q <= '0;
         ovf_q  <= 1'b0;
      end else begin
         data_q <= data_d;
         ctrl_q <= ctrl_d;
         ovf_q  <= ovf_d;
      end
   end

   // Read path is purely combinational on the current address; STEP is write-only.
   always_comb begin
      avs.readdata = '0;
      case (avs.address)
         ADDR_DATA:   avs.readdata = 32'(data_q);
         ADDR_CTRL:   avs.readdata = 32'(ctrl_q);
         ADDR_STEP:   avs.readdata = '0;
         ADDR_STATUS: avs.readdata = {31'b0, ovf_q};
         default:     avs.readdata = '0;
      endcase
   end

   assign out_port = data_q;

`ifdef SYSTEM_COUNTER_PIO_IRQ_EN
   assign irq = ovf_q & ctrl_q[CTRL_IE];
`endif

endmodule

// File: tb/tb_system_counter_pio.sv
// Randomized self-checking bench for system_counter_pio (WIDTH=6, RESET_VALUE=0) against an arithmetic model.
module tb_system_counter_pio;

   localparam int W    = 6;
   localparam int MAXV = (1 << W) - 1;
`ifdef SYSTEM_COUNTER_PIO_IRQ_EN
   localparam int CTRL_MASK = 7;
`else
   localparam int CTRL_MASK = 3;
`endif

   logic         clk;
   logic         reset_n;
   logic [W-1:0] out_port;
`ifdef SYSTEM_COUNTER_PIO_IRQ_EN
   logic         irq;
`endif

   system_counter_pio_if bus_if ();

   system_counter_pio #(.WIDTH(W), .RESET_VALUE(0)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .avs      (bus_if),
      .out_port (out_port)
`ifdef SYSTEM_COUNTER_PIO_IRQ_EN
      ,
      .irq      (irq)
`endif
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   int m_data;
   int m_ctrl;
   int m_ovf;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic void model_reset();
      m_data = 0;
      m_ctrl = 0;
      m_ovf  = 0;
   endfunction

   function automatic void model_write(input int a, input logic [31:0] d);
      int step;
      int r;
      step = int'(d & 32'(MAXV));
      case (a)
         0: m_data = step;
         1: m_ctrl = int'(d & 32'(CTRL_MASK));
         2: begin
            if ((m_ctrl & 2) != 0) begin
               r = m_data - step;
               if (r < 0) begin
                  m_ovf = 1;
                  r = ((m_ctrl & 1) != 0) ? 0 : r + MAXV + 1;
               end
            end else begin
               r = m_data + step;
               if (r > MAXV) begin
                  m_ovf = 1;
                  r = ((m_ctrl & 1) != 0) ? MAXV : r - (MAXV + 1);
               end
            end
            m_data = r;
         end
         default: if (d[0]) m_ovf = 0;
      endcase
   endfunction

   task automatic bus_write(input int a, input logic [31:0] d);
      @(negedge clk);
      bus_if.address    = 2'(a);
      bus_if.writedata  = d;
      bus_if.chipselect = 1'b1;
      bus_if.write_n    = 1'b0;
      @(posedge clk);
      #1;
      bus_if.chipselect = 1'b0;
      bus_if.write_n    = 1'b1;
      model_write(a, d);
   endtask

   task automatic check_all(input string tag);
      int exp_rd;
      check({tag, "_out"}, 32'(out_port), 32'(m_data));
`ifdef SYSTEM_COUNTER_PIO_IRQ_EN
      check({tag, "_irq"}, 32'(irq), 32'(m_ovf & ((m_ctrl >> 2) & 1)));
`endif
      for (int a = 0; a < 4; a++) begin
         bus_if.address = 2'(a);
         #1;
         case (a)
            0: exp_rd = m_data;
            1: exp_rd = m_ctrl;
            2: exp_rd = 0;
            default: exp_rd = m_ovf;
         endcase
         check($sformatf("%s_rd%0d", tag, a), bus_if.readdata, 32'(exp_rd));
      end
   endtask

   initial begin
      int a;
      logic [31:0] d;

      bus_if.address    = 2'd0;
      bus_if.writedata  = 32'd0;
      bus_if.chipselect = 1'b0;
      bus_if.write_n    = 1'b1;
      reset_n = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      check_all("reset");
      @(negedge clk);
      reset_n = 1'b1;

      bus_write(0, 32'h7F);
      check("data7f_out", 32'(out_port), 32'h3F);
      bus_if.address = 2'd0;
      #1;
      check("data7f_rd", bus_if.readdata, 32'h0000_003F);

      bus_write(0, 60); bus_write(1, 0); bus_write(2, 5);
      check("wrap_out", 32'(out_port), 32'd1);
      check_all("wrap");
      bus_write(3, 1);
      check_all("ovf_clr");

      bus_write(0, 60); bus_write(1, 1); bus_write(2, 5);
      check("satadd_out", 32'(out_port), 32'd63);
      check_all("satadd");
      bus_write(2, 1);
      check("satadd2_out", 32'(out_port), 32'd63);

      bus_write(3, 1); bus_write(0, 2); bus_write(1, 3); bus_write(2, 3);
      check("satsub_out", 32'(out_port), 32'd0);
      check_all("satsub");
      bus_write(1, 2); bus_write(0, 2); bus_write(2, 3);
      check("wrapsub_out", 32'(out_port), 32'd63);
      check_all("wrapsub");

      bus_write(3, 1); bus_write(2, 32'hFFFF_FFC0);
      check("step0_out", 32'(out_port), 32'd63);
      check_all("step0");

      bus_write(1, 32'hFFFF_FFFF);
      check_all("ctrl_mask");
      bus_write(1, 4); bus_write(0, 63); bus_write(2, 1);
      check_all("ie_ovf");
`ifdef SYSTEM_COUNTER_PIO_IRQ_EN
      check("irq_set", 32'(irq), 32'd1);
      bus_write(3, 1);
      check("irq_clr", 32'(irq), 32'd0);
      bus_write(2, 1);
      check("irq_set2", 32'(irq), 32'd1);
`endif

      // Asynchronous reset with a write held active across it.
      bus_write(0, 17);
      @(negedge clk);
      bus_if.address    = 2'd0;
      bus_if.writedata  = 32'd33;
      bus_if.chipselect = 1'b1;
      bus_if.write_n    = 1'b0;
      #2;
      reset_n = 1'b0;
      model_reset();
      #1;
      check_all("async_rst");
      bus_if.address = 2'd0;
      @(posedge clk);
      #1;
      check("rst_wr_ignored", 32'(out_port), 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      bus_if.chipselect = 1'b0;
      bus_if.write_n    = 1'b1;
      model_write(0, 32'd33);
      check("first_wr_after_rst", 32'(out_port), 32'd33);

      for (int i = 0; i < 400; i++) begin
         a = int'($urandom_range(0, 3));
         d = $urandom;
         if (a == 2 && $urandom_range(0, 3) != 0) d = 32'($urandom_range(0, 63));
         if (a == 3 && $urandom_range(0, 3) == 0) d[0] = 1'b0;
         bus_write(a, d);
         check_all($sformatf("rnd%0d", i));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
